// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
//   Controls the DDR double frame buffer that the camera-side AXI writer and the
//   HDMI-side AXI reader share. The reader displays one buffer while the writer
//   fills the other. The two buffers swap only at a display vsync, and only after
//   the writer has finished a full frame. All logic runs in the clk_100Mhz domain.
//
// Ports
//   clk_100Mhz          AXI-domain clock
//   rst                 synchronous, active-high reset
//   vsync_in            raw VTG vsync, asynchronous (25 MHz domain)
//   wr_frame_done       1-cycle pulse from the writer: last burst of a frame acked
//   rd_buf_select       reader buffer (1 -> 0x0100_0000, 0 -> 0x0110_0000)
//   wr_buf_select       writer buffer, always ~rd_buf_select
//   vsync_start_pulse   1-cycle pulse: reader resets its address offset
//   wr_frame_start      1-cycle pulse: writer resets its offset and starts a frame
//   wr_active           writer may issue bursts while high
//   swap_cnt            completed swaps (wraps)
//   repeat_cnt          vsyncs with no new frame, i.e. repeated frames (wraps)
//   protocol_err        sticky: wr_frame_done seen outside WRITING
//   state               FSM state (debug)
//   vsync_lost          only when VSYNC_TIMEOUT_EN is defined: watchdog tripped
//
// Build option
//   VSYNC_TIMEOUT_EN    adds a vsync watchdog and the vsync_lost output

module frame_buffer_scheduler #(
    parameter int          CNT_WIDTH         = 16,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES    = 2000000
) (
    input  logic                 clk_100Mhz,
    input  logic                 rst,
    input  logic                 vsync_in,
    input  logic                 wr_frame_done,
    output logic                 rd_buf_select,
    output logic                 wr_buf_select,
    output logic                 vsync_start_pulse,
    output logic                 wr_frame_start,
    output logic                 wr_active,
    output logic [CNT_WIDTH-1:0] swap_cnt,
    output logic [CNT_WIDTH-1:0] repeat_cnt,
    output logic                 protocol_err,
    output logic [1:0]           state
`ifdef VSYNC_TIMEOUT_EN
    ,
    output logic                 vsync_lost
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITING   = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam logic VS_INACTIVE = !VSYNC_ACTIVE_HIGH;

    // ---------------- vsync synchroniser + rising-edge register ----------------
    logic r_vs_meta, r_vs_sync, r_vs_prev, r_vs_rise;
    logic w_sync_act, w_prev_act;

    // XOR with the inactive level turns either polarity into active-high.
    assign w_sync_act = r_vs_sync ^ VS_INACTIVE;
    assign w_prev_act = r_vs_prev ^ VS_INACTIVE;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_vs_meta <= VS_INACTIVE;
            r_vs_sync <= VS_INACTIVE;
            r_vs_prev <= VS_INACTIVE;
            r_vs_rise <= 1'b0;
        end else begin
            r_vs_meta <= vsync_in;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            r_vs_rise <= w_sync_act & ~w_prev_act;
        end
    end

    // ---------------- optional vsync watchdog ----------------
    logic w_timeout;
`ifdef VSYNC_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_vsync_lost;

    // Counts up to TIMEOUT_CYCLES, then holds so the trip fires only once.
    assign w_timeout  = !r_vs_rise && (r_wdog == 32'(TIMEOUT_CYCLES - 1));
    assign vsync_lost = r_vsync_lost;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_wdog       <= '0;
            r_vsync_lost <= 1'b0;
        end else if (r_vs_rise) begin
            r_wdog       <= '0;
            r_vsync_lost <= 1'b0;
        end else begin
            if (r_wdog != 32'(TIMEOUT_CYCLES))
                r_wdog <= r_wdog + 32'd1;
            if (w_timeout)
                r_vsync_lost <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------- FSM ----------------
    state_t r_state, w_state_nx;
    logic   w_swap, w_vsp, w_wfs, w_rep, w_perr;
    logic   r_rd_sel, r_vsp, r_wfs, r_wr_active, r_perr;
    logic [CNT_WIDTH-1:0] r_swap_cnt, r_repeat_cnt;

    always_comb begin
        w_state_nx = IDLE;
        w_swap     = 1'b0;
        w_vsp      = 1'b0;
        w_wfs      = 1'b0;
        w_rep      = 1'b0;
        w_perr     = wr_frame_done && (r_state != WRITING);
        case (r_state)
            IDLE: begin
                if (r_vs_rise) begin
                    w_vsp      = 1'b1;
                    w_wfs      = 1'b1;
                    w_state_nx = WRITING;
                end
            end
            WRITING: begin
                w_state_nx = WRITING;
                if (r_vs_rise && wr_frame_done) begin
                    // frame finished exactly at vsync: swap and keep writing
                    w_swap = 1'b1;
                    w_vsp  = 1'b1;
                    w_wfs  = 1'b1;
                end else if (wr_frame_done) begin
                    w_state_nx = WAIT_SWAP;
                end else if (r_vs_rise) begin
                    // writer still busy: display repeats the current buffer
                    w_vsp = 1'b1;
                    w_rep = 1'b1;
                end
            end
            WAIT_SWAP: begin
                w_state_nx = WAIT_SWAP;
                if (r_vs_rise) begin
                    w_swap     = 1'b1;
                    w_vsp      = 1'b1;
                    w_wfs      = 1'b1;
                    w_state_nx = WRITING;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        // Watchdog trip only happens without a rise, so no pulses are pending.
        if (w_timeout)
            w_state_nx = IDLE;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rd_sel     <= 1'b1;
            r_vsp        <= 1'b0;
            r_wfs        <= 1'b0;
            r_wr_active  <= 1'b0;
            r_swap_cnt   <= '0;
            r_repeat_cnt <= '0;
            r_perr       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rd_sel    <= r_rd_sel ^ w_swap;
            r_vsp       <= w_vsp;
            r_wfs       <= w_wfs;
            r_wr_active <= (w_state_nx == WRITING);
            r_perr      <= r_perr | w_perr;
            if (w_swap)
                r_swap_cnt <= r_swap_cnt + CNT_WIDTH'(1);
            if (w_rep)
                r_repeat_cnt <= r_repeat_cnt + CNT_WIDTH'(1);
        end
    end

    assign rd_buf_select     = r_rd_sel;
    assign wr_buf_select     = ~r_rd_sel;
    assign vsync_start_pulse = r_vsp;
    assign wr_frame_start    = r_wfs;
    assign wr_active         = r_wr_active;
    assign swap_cnt          = r_swap_cnt;
    assign repeat_cnt        = r_repeat_cnt;
    assign protocol_err      = r_perr;
    assign state             = r_state;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler (active-high vsync, short watchdog).
module tb_frame_buffer_scheduler;

    localparam int CW = 16;

    logic          clk_100Mhz = 1'b0;
    logic          rst, vsync_in, wr_frame_done;
    logic          rd_buf_select, wr_buf_select, vsync_start_pulse, wr_frame_start, wr_active;
    logic [CW-1:0] swap_cnt, repeat_cnt;
    logic          protocol_err;
    logic [1:0]    state;
`ifdef VSYNC_TIMEOUT_EN
    logic          vsync_lost;
`endif

    frame_buffer_scheduler #(
        .CNT_WIDTH(CW), .VSYNC_ACTIVE_HIGH(1'b1), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst), .vsync_in(vsync_in), .wr_frame_done(wr_frame_done),
        .rd_buf_select(rd_buf_select), .wr_buf_select(wr_buf_select),
        .vsync_start_pulse(vsync_start_pulse), .wr_frame_start(wr_frame_start),
        .wr_active(wr_active), .swap_cnt(swap_cnt), .repeat_cnt(repeat_cnt),
        .protocol_err(protocol_err), .state(state)
`ifdef VSYNC_TIMEOUT_EN
        , .vsync_lost(vsync_lost)
`endif
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int total = 0, bad = 0;
    int n_vsp = 0, n_wfs = 0, n_selbad = 0;
    int b_vsp, b_wfs;

    // running pulse counts; tests compare deltas
    always @(negedge clk_100Mhz) begin
        if (vsync_start_pulse) n_vsp++;
        if (wr_frame_start)    n_wfs++;
        if (rd_buf_select === wr_buf_select) n_selbad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic vs(input int hi, input int lo);
        vsync_in = 1'b1;
        cyc(hi);
        vsync_in = 1'b0;
        cyc(lo);
    endtask

    task automatic done_pulse();
        wr_frame_done = 1'b1;
        cyc(1);
        wr_frame_done = 1'b0;
    endtask

    task automatic snap();
        b_vsp = n_vsp;
        b_wfs = n_wfs;
    endtask

    initial begin
        rst = 1'b1; vsync_in = 1'b0; wr_frame_done = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(1);
        // reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rd",    32'(rd_buf_select), 32'd1);
        chk("rst_wr",    32'(wr_buf_select), 32'd0);
        chk("rst_wact",  32'(wr_active), 32'd0);
        chk("rst_pulse", 32'({vsync_start_pulse, wr_frame_start}), 32'd0);
        chk("rst_cnts",  32'({swap_cnt, repeat_cnt}), 32'd0);
        chk("rst_perr",  32'(protocol_err), 32'd0);

        // first vsync from IDLE: pulses 3 edges after first active sample
        snap();
        vsync_in = 1'b1;
        cyc(3);
        chk("lat_early", 32'(n_vsp - b_vsp + int'(vsync_start_pulse)), 32'd0);
        cyc(1);
        chk("lat_vsp",   32'(vsync_start_pulse), 32'd1);
        chk("lat_wfs",   32'(wr_frame_start), 32'd1);
        chk("lat_state", 32'(state), 32'd1);
        cyc(1);
        chk("vsp_width", 32'(vsync_start_pulse), 32'd0);
        cyc(795);
        vsync_in = 1'b0;
        cyc(10);
        chk("long_vsp",  32'(n_vsp - b_vsp), 32'd1);
        chk("long_wfs",  32'(n_wfs - b_wfs), 32'd1);
        chk("long_sel",  32'({rd_buf_select, wr_buf_select}), 32'b10);
        chk("long_wact", 32'(wr_active), 32'd1);

        // three vsyncs without a finished frame: repeats only
        snap();
        repeat (3) vs(10, 20);
        chk("rep_cnt",  32'(repeat_cnt), 32'd3);
        chk("rep_swap", 32'(swap_cnt), 32'd0);
        chk("rep_sel",  32'({rd_buf_select, wr_buf_select}), 32'b10);
        chk("rep_vsp",  32'(n_vsp - b_vsp), 32'd3);
        chk("rep_wfs",  32'(n_wfs - b_wfs), 32'd0);
        chk("rep_st",   32'(state), 32'd1);

        // frame done, then swap at the next vsync
        cyc(100);
        done_pulse();
        chk("ws_state", 32'(state), 32'd2);
        chk("ws_wact",  32'(wr_active), 32'd0);
        cyc(300);
        snap();
        vs(10, 20);
        chk("sw_sel",  32'({rd_buf_select, wr_buf_select}), 32'b01);
        chk("sw_cnt",  32'(swap_cnt), 32'd1);
        chk("sw_st",   32'(state), 32'd1);
        chk("sw_wact", 32'(wr_active), 32'd1);
        chk("sw_vsp",  32'(n_vsp - b_vsp), 32'd1);
        chk("sw_wfs",  32'(n_wfs - b_wfs), 32'd1);

        // done coincident with vsync_rise in WRITING
        vsync_in = 1'b1;
        cyc(3);
        wr_frame_done = 1'b1;
        chk("co_wact0", 32'(wr_active), 32'd1);
        cyc(1);
        wr_frame_done = 1'b0;
        chk("co_st",   32'(state), 32'd1);
        chk("co_cnt",  32'(swap_cnt), 32'd2);
        chk("co_sel",  32'({rd_buf_select, wr_buf_select}), 32'b10);
        chk("co_wfs",  32'(wr_frame_start), 32'd1);
        chk("co_wact", 32'(wr_active), 32'd1);
        chk("co_perr", 32'(protocol_err), 32'd0);
        cyc(10);
        vsync_in = 1'b0;
        cyc(20);

        // done while in WAIT_SWAP sets the sticky error
        done_pulse();
        chk("pe_pre", 32'(protocol_err), 32'd0);
        cyc(5);
        done_pulse();
        chk("pe_set", 32'(protocol_err), 32'd1);
        chk("pe_st",  32'(state), 32'd2);
        chk("pe_sel", 32'({rd_buf_select, wr_buf_select}), 32'b10);
        vs(10, 20);
        chk("pe_hold", 32'(protocol_err), 32'd1);
        chk("pe_swap", 32'(swap_cnt), 32'd3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("pe_rst",  32'(protocol_err), 32'd0);
        chk("pe_rsel", 32'({rd_buf_select, wr_buf_select}), 32'b10);

        // done in IDLE also flags
        done_pulse();
        chk("pi_set", 32'(protocol_err), 32'd1);
        chk("pi_st",  32'(state), 32'd0);

`ifdef VSYNC_TIMEOUT_EN
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        vs(10, 20);
        cyc(1100);
        chk("to_lost", 32'(vsync_lost), 32'd1);
        chk("to_st",   32'(state), 32'd0);
        chk("to_wact", 32'(wr_active), 32'd0);
        snap();
        vs(10, 20);
        chk("to_clr",  32'(vsync_lost), 32'd0);
        chk("to_wfs",  32'(n_wfs - b_wfs), 32'd1);
        chk("to_st1",  32'(state), 32'd1);
`endif

        chk("sel_compl", 32'(n_selbad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Sequences the double frame buffer in DDR that is shared by the camera-side AXI writer and the HDMI-side AXI reader.
- Owns buffer selection: the reader displays one buffer while the writer fills the other.
- Swaps the two buffers only at a display vsync, and only after the writer has completed a full frame.
- Synchronises the VTG vsync (25 MHz domain) into the 100 MHz AXI domain and emits the frame-start pulses both masters use to reset their address offsets.

Parameters:
- CNT_WIDTH, 16, width of the swap_cnt and repeat_cnt status counters.
- VSYNC_ACTIVE_HIGH, 1, vsync_in polarity; 1 = active-high, 0 = active-low.
- TIMEOUT_CYCLES, 2000000, clk_100Mhz cycles without a vsync before loss is flagged (optional feature only).

Ports:
- clk_100Mhz  in  1  AXI-domain clock; all logic is in this domain.
- rst  in  1  synchronous, active-high reset.
- vsync_in  in  1  raw VTG vsync from the 25 MHz domain, asynchronous to clk_100Mhz.
- wr_frame_done  in  1  one-cycle pulse from the writer on the final burst response of a frame.
- rd_buf_select  out  1  reader buffer select; 1 -> 0x0100_0000, 0 -> 0x0110_0000.
- wr_buf_select  out  1  writer buffer select; same address encoding; always equals ~rd_buf_select.
- vsync_start_pulse  out  1  one-cycle pulse that resets the reader's address offset.
- wr_frame_start  out  1  one-cycle pulse that resets the writer's offset and starts a frame.
- wr_active  out  1  writer may issue bursts while this is high.
- swap_cnt  out  CNT_WIDTH  number of completed swaps; wraps.
- repeat_cnt  out  CNT_WIDTH  number of vsyncs with no new frame (display repeats a frame); wraps.
- protocol_err  out  1  sticky flag: wr_frame_done received outside WRITING.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset values:
  - state = IDLE (0); rd_buf_select = 1; wr_buf_select = 0.
  - All pulses, wr_active, counters and protocol_err = 0.
  - Synchroniser flops cleared to the inactive vsync level.
  - A reset mid-frame aborts everything; the writer is responsible for draining outstanding bursts.
- Vsync synchroniser:
  - Two-flop sync followed by an edge register.
  - vsync_rise is asserted for exactly one cycle on the inactive-to-active transition.
  - Latency: vsync_rise is asserted in the 3rd clk_100Mhz cycle after the first edge that samples vsync_in active.
  - A vsync active for N cycles produces exactly one rise.
- FSM states: IDLE = 0, WRITING = 1, WAIT_SWAP = 2. Encoding 3 is unused and returns to IDLE.
- IDLE:
  - On vsync_rise: assert vsync_start_pulse and wr_frame_start, go to WRITING.
  - No swap occurs.
- WRITING:
  - wr_active = 1.
  - wr_frame_done without vsync_rise: go to WAIT_SWAP; wr_active drops the next cycle.
  - vsync_rise without done: vsync_start_pulse, repeat_cnt + 1, stay in WRITING. The reader rereads the same buffer.
  - Both in the same cycle: swap immediately. Toggle both selects, assert vsync_start_pulse and wr_frame_start, swap_cnt + 1, stay in WRITING.
- WAIT_SWAP:
  - wr_active = 0.
  - On vsync_rise: toggle both selects, assert vsync_start_pulse and wr_frame_start, swap_cnt + 1, go to WRITING.
- Select timing:
  - Select outputs are registered and change on the same edge the pulses assert.
  - Both selects are stable for the entire frame.
  - rd_buf_select == ~wr_buf_select in every cycle.
- wr_frame_done in IDLE or WAIT_SWAP: ignored for the FSM; sets protocol_err, cleared only by rst.
- Pulse width: all pulse outputs are high for exactly one cycle and are never asserted back-to-back.

Optional Feature:
- Macro: VSYNC_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter clears on every vsync_rise and increments otherwise.
  - Upon reaching TIMEOUT_CYCLES it sets an extra output port, vsync_lost (1 bit, reset 0), forces state to IDLE and deasserts wr_active.
  - Selects are preserved.
  - vsync_lost clears on the next vsync_rise, which restarts the IDLE sequence.
- Undefined: no vsync_lost port, no watchdog logic; the FSM waits indefinitely.

Test Plan:
- Reset release, then vsync_in high for 800 cycles -> exactly one vsync_start_pulse and one wr_frame_start, 3 cycles after vsync is sampled high; state = 1; rd_buf_select = 1, wr_buf_select = 0.
- WRITING, wr_frame_done at cycle 100, vsync rise at cycle 5000 -> wr_active low from cycle 101; selects toggle to rd = 0, wr = 1 with the pulses; swap_cnt = 1.
- Three vsyncs with no wr_frame_done -> repeat_cnt = 3, swap_cnt = 0, selects unchanged, three vsync_start_pulses, no wr_frame_start.
- wr_frame_done coincident with vsync_rise in WRITING -> swap in that cycle, state remains 1, swap_cnt + 1, wr_active never drops.
- wr_frame_done pulsed in WAIT_SWAP -> protocol_err = 1 until rst; state and selects unchanged.
- VSYNC_TIMEOUT_EN with TIMEOUT_CYCLES = 1000 and vsync stopped -> vsync_lost = 1 and state = 0 at cycle 1000; next vsync clears vsync_lost and produces wr_frame_start.
